// File: rtl/oled_frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : oled_frame_streamer
//  Description : Raster-scans a frame through the x/y -> oled_data interface
//                and streams window commands plus RGB565 pixels over SPI.
//  Revision    : 1.0 - initial release
// ============================================================================
module oled_frame_streamer #(
    parameter int WIDTH      = 96,
    parameter int HEIGHT     = 64,
    parameter int SCLK_HALF  = 1,
    parameter int GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] oled_data,
    output logic [6:0]  x,
    output logic [5:0]  y,
    output logic        sample_pixel,
    output logic        frame_begin,
    output logic        busy,
    output logic        oled_cs_n,
    output logic        oled_sclk,
    output logic        oled_mosi,
    output logic        oled_dc
);

    localparam int c_half_w = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int c_gap_w  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [c_half_w-1:0] c_half_last = c_half_w'(SCLK_HALF - 1);
    localparam logic [c_gap_w-1:0]  c_gap_last  = c_gap_w'(GAP_CYCLES - 1);
    localparam logic [6:0]          c_x_last    = 7'(WIDTH - 1);
    localparam logic [5:0]          c_y_last    = 6'(HEIGHT - 1);
    localparam logic [2:0]          c_cmd_last  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CMD_LOAD  = 3'd1,
        S_CMD_SHIFT = 3'd2,
        S_PIX_LOAD  = 3'd3,
        S_PIX_SHIFT = 3'd4,
        S_GAP       = 3'd5
    } state_t;

    state_t              r_state;
    logic [2:0]          r_cmd_idx;
    logic [14:0]         r_shift;
    logic [3:0]          r_bit_cnt;
    logic [c_half_w-1:0] r_half_cnt;
    logic [c_gap_w-1:0]  r_gap_cnt;

    logic [7:0]          w_cmd_byte;
    logic                w_half_done;
    logic                w_last_bit;

    // Column window then row window, both starting at 0.
    always_comb begin
        w_cmd_byte = 8'h00;
        case (r_cmd_idx)
            3'd0:    w_cmd_byte = 8'h15;
            3'd2:    w_cmd_byte = 8'(WIDTH - 1);
            3'd3:    w_cmd_byte = 8'h75;
            3'd5:    w_cmd_byte = 8'(HEIGHT - 1);
            default: w_cmd_byte = 8'h00;
        endcase
    end

    assign w_half_done = (r_half_cnt == c_half_last);
    assign w_last_bit  = (r_state == S_CMD_SHIFT) ? (r_bit_cnt == 4'd7)
                                                  : (r_bit_cnt == 4'd15);

    // The shifter holds only the bits still to come; the current bit lives in oled_mosi.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cmd_idx    <= 3'd0;
            r_shift      <= 15'd0;
            r_bit_cnt    <= 4'd0;
            r_half_cnt   <= '0;
            r_gap_cnt    <= '0;
            x            <= 7'd0;
            y            <= 6'd0;
            sample_pixel <= 1'b0;
            frame_begin  <= 1'b0;
            busy         <= 1'b0;
            oled_cs_n    <= 1'b1;
            oled_sclk    <= 1'b0;
            oled_mosi    <= 1'b0;
            oled_dc      <= 1'b0;
        end else begin
            frame_begin  <= 1'b0;
            sample_pixel <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    oled_cs_n <= 1'b1;
                    oled_sclk <= 1'b0;
                    if (enable) begin
                        r_state     <= S_CMD_LOAD;
                        r_cmd_idx   <= 3'd0;
                        frame_begin <= 1'b1;
                        busy        <= 1'b1;
                        oled_cs_n   <= 1'b0;
                        oled_dc     <= 1'b0;
                    end
                end
                S_CMD_LOAD: begin
                    oled_mosi  <= w_cmd_byte[7];
                    r_shift    <= {w_cmd_byte[6:0], 8'h00};
                    r_bit_cnt  <= 4'd0;
                    r_half_cnt <= '0;
                    r_state    <= S_CMD_SHIFT;
                end
                S_PIX_LOAD: begin
                    oled_mosi  <= oled_data[15];
                    r_shift    <= oled_data[14:0];
                    r_bit_cnt  <= 4'd0;
                    r_half_cnt <= '0;
                    r_state    <= S_PIX_SHIFT;
                end
                S_CMD_SHIFT, S_PIX_SHIFT: begin
                    if (!w_half_done) begin
                        r_half_cnt <= r_half_cnt + 1'b1;
                    end else begin
                        r_half_cnt <= '0;
                        if (!oled_sclk) begin
                            oled_sclk <= 1'b1;
                        end else begin
                            oled_sclk <= 1'b0;
                            r_shift   <= {r_shift[13:0], 1'b0};
                            if (!w_last_bit) begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                                oled_mosi <= r_shift[14];
                            end else if (r_state == S_CMD_SHIFT) begin
                                if (r_cmd_idx != c_cmd_last) begin
                                    r_cmd_idx <= r_cmd_idx + 1'b1;
                                    r_state   <= S_CMD_LOAD;
                                end else begin
                                    x            <= 7'd0;
                                    y            <= 6'd0;
                                    oled_dc      <= 1'b1;
                                    sample_pixel <= 1'b1;
                                    r_state      <= S_PIX_LOAD;
                                end
                            end else if (x != c_x_last) begin
                                x            <= x + 1'b1;
                                sample_pixel <= 1'b1;
                                r_state      <= S_PIX_LOAD;
                            end else if (y != c_y_last) begin
                                x            <= 7'd0;
                                y            <= y + 1'b1;
                                sample_pixel <= 1'b1;
                                r_state      <= S_PIX_LOAD;
                            end else begin
                                x         <= 7'd0;
                                y         <= 6'd0;
                                oled_cs_n <= 1'b1;
                                r_gap_cnt <= '0;
                                r_state   <= S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    oled_cs_n <= 1'b1;
                    oled_sclk <= 1'b0;
                    if (r_gap_cnt != c_gap_last) begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end else if (enable) begin
                        r_cmd_idx   <= 3'd0;
                        frame_begin <= 1'b1;
                        oled_cs_n   <= 1'b0;
                        oled_dc     <= 1'b0;
                        r_state     <= S_CMD_LOAD;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/oled_frame_streamer.md
Name: oled_frame_streamer

Overview:
- Display-side consumer of the x/y → oled_data pixel interface used by every screen module.
- Scans a full frame in raster order and drives the x/y coordinates out to the selected screen module.
- Samples the returned 16-bit RGB565 oled_data for each pixel and serialises it to the OLED over a 4-wire SPI link (cs_n, sclk, mosi, dc).
- Each frame is preceded by a column/row window command sequence; frames repeat continuously while enable is high.

Parameters:
WIDTH, 96, pixels per row; 2..128.
HEIGHT, 64, rows per frame; 2..64.
SCLK_HALF, 1, clk cycles per sclk half-period; ≥1.
GAP_CYCLES, 16, idle clk cycles with cs_n high between frames; ≥1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  frames run while high
oled_data  in  16  pixel colour for current x,y (combinational from screen module)
x  out  7  current pixel column
y  out  6  current pixel row
sample_pixel  out  1  high for the cycle in which oled_data is captured
frame_begin  out  1  one-cycle pulse at start of each frame
busy  out  1  high in every state except IDLE
oled_cs_n  out  1  SPI chip select, active low
oled_sclk  out  1  SPI clock, mode 0 (idle low)
oled_mosi  out  1  SPI data, MSB first
oled_dc  out  1  0 = command byte, 1 = pixel data

Behaviour:
- Reset (async, any state): state=IDLE, x=0, y=0, sample_pixel=0, frame_begin=0, busy=0, oled_cs_n=1, oled_sclk=0, oled_mosi=0, oled_dc=0, all counters 0.
- All outputs are registered.
- States: IDLE, CMD_LOAD, CMD_SHIFT, PIX_LOAD, PIX_SHIFT, GAP.
- IDLE:
  - cs_n=1, sclk=0.
  - If enable=1 → CMD_LOAD with cmd_idx=0; frame_begin=1 for exactly that first CMD_LOAD cycle.
- CMD_LOAD (1 cycle):
  - Shifter ← cmd[cmd_idx]; cs_n=0, dc=0.
  - Command table: 0x15, 0x00, WIDTH-1, 0x75, 0x00, HEIGHT-1.
  - → CMD_SHIFT.
- Bit timing, both shift states:
  - Each bit is SCLK_HALF cycles with sclk=0, then SCLK_HALF cycles with sclk=1.
  - mosi = shifter MSB; it changes only in the first cycle of a low phase and is stable across each rising edge.
  - The shifter shifts left after the high phase.
  - sclk returns to 0 after the last bit.
- CMD_SHIFT:
  - After 8 bits, if cmd_idx<5: cmd_idx++ → CMD_LOAD.
  - Otherwise x←0, y←0 → PIX_LOAD.
- PIX_LOAD (1 cycle):
  - sample_pixel=1, dc=1.
  - Shifter ← oled_data at the end of the cycle.
  - x,y were updated on entry, so they are stable for the whole sampling cycle.
  - → PIX_SHIFT.
- PIX_SHIFT: after 16 bits:
  - x<WIDTH-1: x++ → PIX_LOAD.
  - x=WIDTH-1, y<HEIGHT-1: x←0, y++ → PIX_LOAD.
  - x=WIDTH-1, y=HEIGHT-1: x←0, y←0, cs_n←1 → GAP.
- GAP:
  - Hold cs_n=1, sclk=0 for GAP_CYCLES cycles.
  - Then → CMD_LOAD if enable=1 (new frame_begin pulse), else → IDLE.
- enable deasserted mid-frame: the current frame completes; enable is only checked in IDLE and at the end of GAP.
- Frame length in clk cycles:
  - 6·(1+16·SCLK_HALF) + WIDTH·HEIGHT·(1+32·SCLK_HALF) + GAP_CYCLES.
  - Defaults (SCLK_HALF=1, GAP_CYCLES=16): 102 + 6144·33 + 16 = 202870.
- cs_n stays low continuously from the first CMD_LOAD until the last pixel bit; no deassertion between bytes.
- x,y never exceed WIDTH-1 / HEIGHT-1; both are zero outside PIX_LOAD/PIX_SHIFT.
- Widths: WIDTH-1 and HEIGHT-1 are zero-extended to 8 bits in the command bytes.

Test Plan:
1. Reset: assert reset mid-PIX_SHIFT (WIDTH=4, HEIGHT=2) → same cycle: cs_n=1, sclk=0, x=0, y=0, busy=0; after release with enable=0 → stays IDLE, no sclk edges.
2. Command phase: WIDTH=4, HEIGHT=2, enable=1 → frame_begin one cycle; dc=0 and SPI monitor decodes bytes 0x15,0x00,0x03,0x75,0x00,0x01; 102 cycles from CMD_LOAD to the first PIX_LOAD.
3. Pixel scan: oled_data = {x,y} pattern (e.g. 16'h0100·x + y) → monitor decodes 8 words in raster order (0,0)…(3,1); dc=1; sample_pixel exactly 8 times; mosi stable at every sclk rising edge.
4. Frame timing/gap: WIDTH=4, HEIGHT=2, SCLK_HALF=1, GAP_CYCLES=16 → consecutive frame_begin pulses exactly 382 cycles apart; cs_n high for 16 cycles between frames.
5. Enable drop: deassert enable mid-frame → frame completes all 8 pixels, enters IDLE after GAP, busy=0, no further frame_begin.
6. SCLK_HALF=3 → each sclk high and low phase lasts 3 cycles; decoded data is identical to scenario 3; frame length is 6·49 + 8·97 + 16 = 1086 cycles.
